// File: rtl/rx_frame_parser.sv
// Byte-stream frame parser: SOF, LEN, payload, XOR checksum. Buffers the payload
// and replays it on a valid/ready stream once the checksum has been verified.
module rx_frame_parser #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD_data_ready,
    input  logic [7:0] RxD_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Output handshake: a payload byte transfers on every posedge where out_valid
    // and out_ready are both 1; out_data/out_last hold while out_valid && !out_ready.

    typedef enum logic [2:0] {IDLE, GET_LEN, GET_PAY, GET_CHK, EMIT} state_t;

    localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_LEN = 2'd0;
    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    state_t        state, state_nxt;
    logic [7:0]    len, len_nxt;
    logic [7:0]    xsum, xsum_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [IW-1:0] rd_idx, rd_nxt, rd_inc;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt, last_nxt, ok_nxt, err_nxt, busy_nxt, wr_en;
    logic [1:0]    code_nxt;
    logic [7:0]    buffer [MAX_LEN];

    assign rd_inc    = rd_idx + IW'(1);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        xsum_nxt  = xsum;
        idx_nxt   = idx;
        rd_nxt    = rd_idx;
        tmo_nxt   = '0;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        last_nxt  = out_last;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (RxD_data_ready && RxD_data == SOF) state_nxt = GET_LEN;
            end
            GET_LEN: begin
                if (RxD_data_ready) begin
                    if (RxD_data == 8'd0 || RxD_data > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_LEN;
                        state_nxt = IDLE;
                    end else begin
                        len_nxt   = RxD_data;
                        xsum_nxt  = RxD_data;
                        idx_nxt   = '0;
                        state_nxt = GET_PAY;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TMO;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            GET_PAY: begin
                if (RxD_data_ready) begin
                    wr_en    = 1'b1;
                    xsum_nxt = xsum ^ RxD_data;
                    idx_nxt  = idx + IW'(1);
                    if (8'(idx) == len - 8'd1) state_nxt = GET_CHK;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TMO;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            GET_CHK: begin
                if (RxD_data_ready) begin
                    if (RxD_data == xsum) begin
                        // First payload byte is presented together with the frame_ok pulse.
                        ok_nxt    = 1'b1;
                        valid_nxt = 1'b1;
                        rd_nxt    = '0;
                        data_nxt  = buffer[0];
                        last_nxt  = (len == 8'd1);
                        state_nxt = EMIT;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CHK;
                        state_nxt = IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TMO;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            EMIT: begin
                if (RxD_data_ready) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVR;
                end
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        rd_nxt   = rd_inc;
                        data_nxt = buffer[rd_inc];
                        last_nxt = (8'(rd_inc) == len - 8'd1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= '0;
            xsum      <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            tmo_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            xsum      <= xsum_nxt;
            idx       <= idx_nxt;
            rd_idx    <= rd_nxt;
            tmo_cnt   <= tmo_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_last  <= last_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            busy      <= busy_nxt;
        end
    end

    // Payload store keeps stale contents across frames; nothing reads past LEN.
    always_ff @(posedge clk) begin
        if (wr_en) buffer[idx] <= RxD_data;
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: frame vector table plus hand-written
// sequences for timeout, overrun, and reset corners.
module tb_rx_frame_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] dbg_state;

    rx_frame_parser #(.SOF(8'hA5), .MAX_LEN(16), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset),
        .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0, err_cnt = 0, both_hi = 0, unstable = 0, cyc = 0;
    logic [8:0] exp_q[$];
    logic [8:0] sb_e;
    logic       m_stall = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counters, stall stability, and payload scoreboard.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (frame_ok && frame_err) both_hi++;
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (m_stall && out_valid && (out_data !== m_data || out_last !== m_last)) unstable++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got %0h with no expected byte", out_data);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_byte", {out_last, out_data}, sb_e);
            end
        end
        m_stall = out_valid && !out_ready;
        m_data  = out_data;
        m_last  = out_last;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        RxD_data_ready = 1'b1;
        RxD_data       = b;
        @(negedge clk);
        RxD_data_ready = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 300) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        int           n;
        logic [159:0] b;
        int           np;
        logic [127:0] p;
        int           ok;
        int           err;
        logic [1:0]   code;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];
    int   ok0, err0, k, seen;

    initial begin
        vec[0] = '{n:6, b:160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}), np:3,
                   p:128'({8'h11, 8'h22, 8'h33}), ok:1, err:0, code:2'd0};
        vec[1] = '{n:5, b:160'({8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}), np:0, p:'0, ok:0, err:1, code:2'd1};
        vec[2] = '{n:2, b:160'({8'hA5, 8'h00}), np:0, p:'0, ok:0, err:1, code:2'd0};
        vec[3] = '{n:2, b:160'({8'hA5, 8'h11}), np:0, p:'0, ok:0, err:1, code:2'd0};
        vec[4] = '{n:4, b:160'({8'hA5, 8'h01, 8'h7E, 8'h7F}), np:1, p:128'({8'h7E}), ok:1, err:0, code:2'd0};
        vec[5] = '{n:7, b:160'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01}), np:1,
                   p:128'({8'h00}), ok:1, err:0, code:2'd0};
        vec[6] = '{n:19, b:160'({8'hA5, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h10}), np:16,
                   p:128'h000102030405060708090A0B0C0D0E0F, ok:1, err:0, code:2'd0};
        vec[7] = '{n:5, b:160'({8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFD}), np:2,
                   p:128'({8'hA5, 8'h5A}), ok:1, err:0, code:2'd0};

        reset          = 1'b0;
        RxD_data_ready = 1'b0;
        RxD_data       = 8'h00;
        out_ready      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_last", out_last, 0);
        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            ok0  = ok_cnt;
            err0 = err_cnt;
            for (int j = 0; j < vec[v].np; j++)
                exp_q.push_back({(j == vec[v].np - 1), vec[v].p[8*(vec[v].np-1-j) +: 8]});
            for (int j = 0; j < vec[v].n; j++)
                send_byte(vec[v].b[8*(vec[v].n-1-j) +: 8]);
            drain();
            check($sformatf("vec%0d_ok", v), ok_cnt - ok0, vec[v].ok);
            check($sformatf("vec%0d_err", v), err_cnt - err0, vec[v].err);
            if (vec[v].err != 0) check($sformatf("vec%0d_code", v), err_code, vec[v].code);
            check($sformatf("vec%0d_busy", v), busy, 0);
        end

        // Cycle-exact emission: frame_ok with first byte, then one byte per cycle.
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        check("emit0_ok", frame_ok, 1);
        check("emit0_valid", out_valid, 1);
        check("emit0_data", {out_last, out_data}, {1'b0, 8'h11});
        @(negedge clk);
        check("emit1_ok_pulse", frame_ok, 0);
        check("emit1_data", {out_valid, out_last, out_data}, {2'b10, 8'h22});
        @(negedge clk);
        check("emit2_data", {out_valid, out_last, out_data}, {2'b11, 8'h33});
        @(negedge clk);
        check("emit3_valid", out_valid, 0);
        check("emit3_busy", busy, 0);
        drain();

        // Timeout after silence: error exactly 50 cycles after the last strobe.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (frame_err) begin k = i; break; end
        end
        check("tmo_latency", k, 50);
        check("tmo_code", err_code, 2);
        check("tmo_busy", busy, 0);
        repeat (3) @(negedge clk);

        // Strobe one cycle before expiry restarts the count.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        seen = 0;
        repeat (47) begin
            @(negedge clk);
            if (frame_err) seen++;
        end
        send_byte(8'hBB);
        if (frame_err) seen++;
        check("tmo49_no_err", seen, 0);
        check("tmo49_state", dbg_state, 3);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (frame_err) begin k = i; break; end
        end
        check("tmo49_latency", k, 50);
        check("tmo49_code", err_code, 2);
        repeat (3) @(negedge clk);

        // Strobe on the expiry cycle itself is taken as data.
        ok0  = ok_cnt;
        err0 = err_cnt;
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b1, 8'hBB});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        repeat (48) @(negedge clk);
        send_byte(8'hBB);
        send_byte(8'h13);
        drain();
        check("tmo50_ok", ok_cnt - ok0, 1);
        check("tmo50_err", err_cnt - err0, 0);

        // Overrun while the consumer stalls.
        out_ready = 1'b0;
        ok0  = ok_cnt;
        err0 = err_cnt;
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h34});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'h24);
        repeat (4) @(negedge clk);
        send_byte(8'h55);
        repeat (14) @(negedge clk);
        check("ovr_hold", {out_valid, out_last, out_data}, {2'b10, 8'h12});
        check("ovr_code", err_code, 3);
        check("ovr_err", err_cnt - err0, 1);
        out_ready = 1'b1;
        drain();
        check("ovr_ok", ok_cnt - ok0, 1);
        check("ovr_busy", busy, 0);

        // Reset mid-frame and mid-emission: no pulses, immediate idle.
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        check("rst_emit_valid_pre", out_valid, 1);
        repeat (2) @(negedge clk);
        ok0 = ok_cnt;
        #2 reset = 1'b0;
        #1;
        check("rst_emit_valid", out_valid, 0);
        check("rst_emit_busy", busy, 0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_ok", ok_cnt - ok0, 0);
        check("rst_no_err", err_cnt - err0, 0);
        exp_q.push_back({1'b1, 8'h7E});
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        check("post_rst_data", {frame_ok, out_valid, out_last, out_data}, {3'b111, 8'h7E});
        drain();
        check("post_rst_ok", ok_cnt - ok0, 1);

        check("ok_err_overlap", both_hi, 0);
        check("stall_stable", unstable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
